mac_sequencer: RTL and testbench

Upstream feeder for the half-precision multiply-accumulate processing element. It buffers one kernel window of KERNEL_LEN (pixel, weight) pairs and clears the PE accumulator. It then streams the pairs into the PE one per cycle and captures the finished dot product behind a valid/ready output handshake. One instance sits in front of each PE in the convolution array.

---
 rtl/mac_sequencer_pkg.sv | 17 +
 rtl/mac_operand_buffer.sv | 29 ++
 rtl/mac_sequencer.sv | 151 +++++++++++++++
 tb/tb_mac_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sequencer_pkg.sv
// Shared constants for the MAC sequencer: operand width,
// the fp16 zero operand and the sequencer state encoding.
package mac_sequencer_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int KERNEL_LEN_DEF = 9;
    localparam int IDX_W_DEF      = 4;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    localparam logic [2:0] ST_LOAD    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_STREAM  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_OUT     = 3'd4;

endpackage

// File: rtl/mac_operand_buffer.sv
// Kernel-window register file holding {pixel, weight} pairs:
// one synchronous write port, one combinational read port.
module mac_operand_buffer
    import mac_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int KERNEL_LEN = KERNEL_LEN_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        waddr_i,
    input  logic [2*DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]        raddr_i,
    output logic [2*DATA_WIDTH-1:0] rdata_o
);

    logic [2*DATA_WIDTH-1:0] mem_q [KERNEL_LEN];

    // Contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mac_sequencer.sv
// Buffers one kernel window, clears the PE, streams the pairs
// and captures the dot product behind a valid/ready handshake.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int KERNEL_LEN = KERNEL_LEN_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_pixel,
    input  logic [DATA_WIDTH-1:0] load_weight,
    output logic [DATA_WIDTH-1:0] pe_floatA,
    output logic [DATA_WIDTH-1:0] pe_floatB,
    output logic                  pe_clear,
    input  logic [DATA_WIDTH-1:0] pe_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [DATA_WIDTH-1:0] OP_ZERO = DATA_WIDTH'(FP16_ZERO);

    logic [2:0]            state_q, state_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic                  clear_q, clear_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                    load_hs;
    logic                    wr_last;
    logic                    rd_last;
    logic [IDX_W-1:0]        rd_addr;
    logic [2*DATA_WIDTH-1:0] rd_data;

    assign load_ready = (state_q == ST_LOAD) && !reset;
    assign load_hs    = load_valid && load_ready;
    assign wr_last    = (wr_idx_q == LAST_IDX);
    assign rd_last    = (rd_idx_q == LAST_IDX);

    // Read the pair that goes onto the operands at the next edge.
    always_comb begin
        rd_addr = '0;
        if (state_q == ST_STREAM && !rd_last) begin
            rd_addr = rd_idx_q + IDX_ONE;
        end
    end

    mac_operand_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .KERNEL_LEN (KERNEL_LEN),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (load_hs),
        .waddr_i (wr_idx_q),
        .wdata_i ({load_pixel, load_weight}),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        op_a_d      = OP_ZERO;
        op_b_d      = OP_ZERO;
        clear_d     = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            ST_LOAD: begin
                if (load_hs) begin
                    if (wr_last) begin
                        wr_idx_d = '0;
                        clear_d  = 1'b1;
                        state_d  = ST_CLEAR;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_ONE;
                    end
                end
            end
            ST_CLEAR: begin
                rd_idx_d         = '0;
                {op_a_d, op_b_d} = rd_data;
                state_d          = ST_STREAM;
            end
            ST_STREAM: begin
                if (rd_last) begin
                    rd_idx_d = '0;
                    state_d  = ST_CAPTURE;
                end else begin
                    rd_idx_d         = rd_addr;
                    {op_a_d, op_b_d} = rd_data;
                end
            end
            ST_CAPTURE: begin
                // Operands are +0 here, so the PE sum is already final.
                out_data_d  = pe_result;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            op_a_q      <= OP_ZERO;
            op_b_q      <= OP_ZERO;
            clear_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            clear_q     <= clear_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign pe_floatA = op_a_q;
    assign pe_floatB = op_b_q;
    assign pe_clear  = clear_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: fp16 PE model plus a sum-of-products
// reference built from the pairs offered on the load port.
module tb_mac_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        load_valid, load_ready;
    logic [15:0] load_pixel, load_weight;
    logic [15:0] pe_floatA, pe_floatB, pe_result;
    logic        pe_clear;
    logic        out_valid, out_ready;
    logic [15:0] out_data;

    logic        load_valid1, load_ready1;
    logic [15:0] load_pixel1, load_weight1;
    logic [15:0] pe_floatA1, pe_floatB1, pe_result1;
    logic        pe_clear1;
    logic        out_valid1, out_ready1;
    logic [15:0] out_data1;

    int tests = 0;
    int fails = 0;

    logic [15:0] px [9];
    logic [15:0] wt [9];
    logic [15:0] tbl [8];

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        int  f;
        e = int'(h[14:10]);
        f = int'(h[9:0]);
        if (e == 0) m = real'(f) / 1024.0 * (2.0 ** (-14));
        else        m = (1.0 + real'(f) / 1024.0) * (2.0 ** (e - 15));
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        real        a;
        int         e;
        int         mi;
        logic       sg;
        logic [4:0] ev;
        logic [9:0] mv;
        if (x == 0.0) return 16'h0000;
        sg = (x < 0.0);
        a  = sg ? -x : x;
        e  = 15;
        while (a >= 2.0 && e < 30) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
        mi = int'((a - 1.0) * 1024.0);
        ev = e[4:0];
        mv = mi[9:0];
        return {sg, ev, mv};
    endfunction

    // Behavioural PE: clear on pe_clear, else accumulate A*B.
    real acc  = 0.0;
    real acc1 = 0.0;
    always @(posedge clk) begin
        if (pe_clear) acc <= 0.0;
        else acc <= acc + h2r(pe_floatA) * h2r(pe_floatB);
        if (pe_clear1) acc1 <= 0.0;
        else acc1 <= acc1 + h2r(pe_floatA1) * h2r(pe_floatB1);
    end
    assign pe_result  = r2h(acc);
    assign pe_result1 = r2h(acc1);

    mac_sequencer #(.DATA_WIDTH(16), .KERNEL_LEN(9), .IDX_W(4)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_pixel(load_pixel), .load_weight(load_weight),
        .pe_floatA(pe_floatA), .pe_floatB(pe_floatB),
        .pe_clear(pe_clear), .pe_result(pe_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    mac_sequencer #(.DATA_WIDTH(16), .KERNEL_LEN(1), .IDX_W(1)) dut1 (
        .clk(clk), .reset(reset),
        .load_valid(load_valid1), .load_ready(load_ready1),
        .load_pixel(load_pixel1), .load_weight(load_weight1),
        .pe_floatA(pe_floatA1), .pe_floatB(pe_floatB1),
        .pe_clear(pe_clear1), .pe_result(pe_result1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 9-pair window. abort_at >= 0 resets mid-stream at that pair.
    task automatic window(input int gap, input int hold, input int abort_at);
        real         s;
        logic [15:0] expv;
        s = 0.0;
        for (int i = 0; i < 9; i++) s += h2r(px[i]) * h2r(wt[i]);
        expv = r2h(s);
        out_ready = (hold == 0);
        for (int i = 0; i < 9; i++) begin
            load_valid  = 1'b1;
            load_pixel  = px[i];
            load_weight = wt[i];
            for (int t = 0; t < 50 && !load_ready; t++) @(negedge clk);
            chk("load_ready", load_ready, 1);
            @(negedge clk);
            load_valid = 1'b0;
            if (i < 8) begin
                for (int g = 0; g < gap; g++) begin
                    chk("ready_in_gap", load_ready, 1);
                    @(negedge clk);
                end
            end
        end
        chk("clear_pulse", {pe_clear, pe_floatA, pe_floatB}, {1'b1, 32'h0});
        for (int i = 0; i < 9; i++) begin
            load_valid  = 1'b1;
            load_pixel  = 16'hFFFF;
            load_weight = 16'hFFFF;
            @(negedge clk);
            chk("stream_op", {pe_clear, pe_floatA, pe_floatB},
                {1'b0, px[i], wt[i]});
            chk("no_load_in_stream", load_ready, 0);
            if (i == abort_at) begin
                reset = 1'b1;
                load_valid = 1'b0;
                @(negedge clk);
                chk("abort_state",
                    {load_ready, out_valid, out_data, pe_clear, pe_floatA, pe_floatB},
                    64'h0);
                reset = 1'b0;
                @(negedge clk);
                chk("abort_ready", load_ready, 1);
                return;
            end
        end
        load_valid  = 1'b0;
        load_pixel  = 16'h0;
        load_weight = 16'h0;
        @(negedge clk);
        chk("capture", {out_valid, pe_floatA, pe_floatB}, 33'h0);
        @(negedge clk);
        chk("out_valid_rise", {out_valid, out_data}, {1'b1, expv});
        for (int h = 0; h < hold; h++) begin
            load_valid = h[0];
            chk("hold", {out_valid, out_data, load_ready}, {1'b1, expv, 1'b0});
            @(negedge clk);
        end
        load_valid = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        chk("handshake", {out_valid, load_ready}, 2'b01);
    endtask

    initial begin
        tbl = '{16'h0000, 16'h3800, 16'h3C00, 16'h4000,
                16'h4200, 16'hBC00, 16'hC000, 16'hB800};
        reset = 1'b1;
        load_valid = 1'b0; load_pixel = 16'h0; load_weight = 16'h0;
        out_ready = 1'b1;
        load_valid1 = 1'b0; load_pixel1 = 16'h0; load_weight1 = 16'h0;
        out_ready1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state",
            {load_ready, out_valid, out_data, pe_clear, pe_floatA, pe_floatB}, 64'h0);
        chk("reset_state_k1",
            {load_ready1, out_valid1, out_data1, pe_clear1, pe_floatA1, pe_floatB1}, 64'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", load_ready, 1);

        for (int i = 0; i < 9; i++) begin px[i] = 16'h3C00; wt[i] = 16'h3C00; end
        window(0, 0, -1);

        for (int i = 0; i < 9; i++) begin px[i] = 16'h4000; wt[i] = 16'h3800; end
        window(2, 0, -1);

        for (int i = 0; i < 9; i++) begin
            px[i] = 16'h3C00;
            wt[i] = i[0] ? 16'hBC00 : 16'h3C00;
        end
        window(0, 0, -1);

        for (int i = 0; i < 9; i++) begin px[i] = 16'h3C00; wt[i] = 16'h3C00; end
        window(0, 20, -1);

        for (int i = 0; i < 9; i++) begin px[i] = 16'h4200; wt[i] = 16'hC000; end
        window(0, 0, 4);
        for (int i = 0; i < 9; i++) begin px[i] = 16'h3C00; wt[i] = 16'h3C00; end
        window(0, 0, -1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 9; i++) begin
                px[i] = tbl[$urandom_range(0, 7)];
                wt[i] = tbl[$urandom_range(0, 7)];
            end
            window(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
        end

        load_valid1  = 1'b1;
        load_pixel1  = 16'h4200;
        load_weight1 = 16'h4000;
        chk("k1_ready", load_ready1, 1);
        @(negedge clk);
        load_valid1 = 1'b0;
        chk("k1_clear", {pe_clear1, pe_floatA1, pe_floatB1}, {1'b1, 32'h0});
        @(negedge clk);
        chk("k1_stream", {pe_clear1, pe_floatA1, pe_floatB1},
            {1'b0, 16'h4200, 16'h4000});
        @(negedge clk);
        chk("k1_capture", {out_valid1, pe_floatA1, pe_floatB1}, 33'h0);
        @(negedge clk);
        chk("k1_out", {out_valid1, out_data1}, {1'b1, 16'h4600});
        @(negedge clk);
        chk("k1_done", {out_valid1, load_ready1}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
